fc_tx_credit_gate: RTL

Parametrised transmit-side PCIe flow-control credit gate for NUM_VC virtual channels, each with Posted (P), Non-Posted (NP) and Completion (Cpl) header/data credit pools. It tracks Credit Limit (CL) from InitFC/UpdateFC DLLPs and Credits Consumed (CC) from granted TLPs. It grants a transmit request only when spec modulo arithmetic permits. It sits between the TLP arbiter and the DLLP receive decoder. It generalises the single-VC TX FC controller with per-VC init tracking, infinite credits, wrap-safe arithmetic, single-cycle DLLP capture and a double-consume-safe handshake.

---
 rtl/fc_tx_credit_gate_pkg.sv | 26 ++
 rtl/fc_credit_pool.sv | 78 +++++++
 rtl/fc_tx_credit_gate.sv | 98 +++++++++
 3 files changed

// File: rtl/fc_tx_credit_gate_pkg.sv
// Shared types, constants and the wrap-safe credit check for the TX credit gate.
package fc_pkg;

  typedef enum logic [1:0] {
    FC_P    = 2'b00,
    FC_NP   = 2'b01,
    FC_CPL  = 2'b10,
    FC_RSVD = 2'b11
  } fc_type_e;

  localparam int DW_PER_DATA_CREDIT = 4;

  // Modulo-2^width check: the remaining window after consuming req must not
  // have gone "negative", i.e. land in the upper half of the number space.
  function automatic logic fc_credit_ok(input logic [31:0] cl,
                                        input logic [31:0] cc,
                                        input logic [31:0] req,
                                        input int          width);
    logic [31:0] mask;
    logic [31:0] diff;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    diff = (cl - (cc + req)) & mask;
    return (diff <= (32'd1 << (width - 1)));
  endfunction

endpackage

// File: rtl/fc_credit_pool.sv
// One flow-control pool (header + data): credit limit, credits consumed and
// infinite flags, with InitFC load, UpdateFC overwrite and grant consume.
module fc_credit_pool
  import fc_pkg::*;
#(
  parameter int HDR_W  = 8,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              update_i,
  input  logic [HDR_W-1:0]  fc_hdr_i,
  input  logic [DATA_W-1:0] fc_data_i,
  input  logic              consume_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              pass_o
);

  logic [HDR_W-1:0]  cl_hdr_q,  cl_hdr_d,  cc_hdr_q,  cc_hdr_d;
  logic [DATA_W-1:0] cl_data_q, cl_data_d, cc_data_q, cc_data_d;
  logic              inf_hdr_q, inf_hdr_d, inf_data_q, inf_data_d;
  logic              hdr_ok, data_ok;

  // Next-state: load/update touch CL, consume touches CC; both may land together.
  always_comb begin
    cl_hdr_d   = cl_hdr_q;
    cc_hdr_d   = cc_hdr_q;
    cl_data_d  = cl_data_q;
    cc_data_d  = cc_data_q;
    inf_hdr_d  = inf_hdr_q;
    inf_data_d = inf_data_q;
    if (load_i) begin
      cl_hdr_d   = fc_hdr_i;
      cl_data_d  = fc_data_i;
      cc_hdr_d   = '0;
      cc_data_d  = '0;
      inf_hdr_d  = (fc_hdr_i == '0);
      inf_data_d = (fc_data_i == '0);
    end else if (update_i) begin
      if (!inf_hdr_q)  cl_hdr_d  = fc_hdr_i;
      if (!inf_data_q) cl_data_d = fc_data_i;
    end
    if (consume_i) begin
      if (!inf_hdr_q)  cc_hdr_d  = cc_hdr_q + HDR_W'(1);
      if (!inf_data_q) cc_data_d = cc_data_q + req_data_i;
    end
  end

  // Pool state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cl_hdr_q   <= '0;
      cc_hdr_q   <= '0;
      cl_data_q  <= '0;
      cc_data_q  <= '0;
      inf_hdr_q  <= 1'b0;
      inf_data_q <= 1'b0;
    end else begin
      cl_hdr_q   <= cl_hdr_d;
      cc_hdr_q   <= cc_hdr_d;
      cl_data_q  <= cl_data_d;
      cc_data_q  <= cc_data_d;
      inf_hdr_q  <= inf_hdr_d;
      inf_data_q <= inf_data_d;
    end
  end

  // Gate check on pre-update state; zero-length requests skip the data check.
  always_comb begin
    hdr_ok  = inf_hdr_q ||
              fc_credit_ok(32'(cl_hdr_q), 32'(cc_hdr_q), 32'd1, HDR_W);
    data_ok = inf_data_q || (req_data_i == '0) ||
              fc_credit_ok(32'(cl_data_q), 32'(cc_data_q), 32'(req_data_i), DATA_W);
    pass_o  = hdr_ok && data_ok;
  end

endmodule

// File: rtl/fc_tx_credit_gate.sv
// TX flow-control credit gate: per-VC init tracking, request decode and the
// registered grant pulse over NUM_VC x {P, NP, Cpl} credit pools.
module fc_tx_credit_gate
  import fc_pkg::*;
#(
  parameter  int NUM_VC = 1,
  parameter  int HDR_W  = 8,
  parameter  int DATA_W = 12,
  parameter  int LEN_W  = 10,
  localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fc_valid_i,
  input  logic              fc_init_i,
  input  logic [VC_W-1:0]   fc_vc_i,
  input  logic [1:0]        fc_type_i,
  input  logic [HDR_W-1:0]  fc_hdr_i,
  input  logic [DATA_W-1:0] fc_data_i,
  input  logic              req_valid_i,
  input  logic [VC_W-1:0]   req_vc_i,
  input  logic [1:0]        req_type_i,
  input  logic [LEN_W-1:0]  req_len_i,
  output logic              grant_o,
  output logic [NUM_VC-1:0] vc_ready_o
);

  localparam int RLW = LEN_W + 1;
  localparam int DSH = $clog2(DW_PER_DATA_CREDIT);

  logic [NUM_VC-1:0][2:0] mask_q, mask_d;
  logic [NUM_VC-1:0][2:0] load, upd, req_hit, consume, pass;
  logic [NUM_VC-1:0]      ready;
  logic                   grant_q, grant_d, sel_ok;
  logic [RLW-1:0]         len_rnd;
  logic [DATA_W-1:0]      req_data;

  // Required data credits: ceil(len / 4 DW).
  always_comb begin
    len_rnd  = {1'b0, req_len_i} + RLW'(DW_PER_DATA_CREDIT - 1);
    req_data = DATA_W'(len_rnd >> DSH);
  end

  // Decode DLLP and request targets; InitFC only before ready, UpdateFC only after.
  always_comb begin
    load    = '0;
    upd     = '0;
    req_hit = '0;
    consume = '0;
    ready   = '0;
    sel_ok  = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      ready[v] = &mask_q[v];
      for (int t = 0; t < 3; t++) begin
        if (fc_valid_i && fc_vc_i == VC_W'(v) && fc_type_i == 2'(t)) begin
          load[v][t] = fc_init_i && !ready[v];
          upd[v][t]  = !fc_init_i && ready[v];
        end
        req_hit[v][t] = (req_vc_i == VC_W'(v)) && (req_type_i == 2'(t));
        if (req_hit[v][t] && ready[v] && pass[v][t]) sel_ok = 1'b1;
      end
    end
    mask_d  = mask_q | load;
    grant_d = req_valid_i && !grant_q && sel_ok;
    if (grant_d) consume = req_hit;
  end

  // Init masks and the grant register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q  <= '0;
      grant_q <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o    = grant_q;
  assign vc_ready_o = ready;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    for (genvar t = 0; t < 3; t++) begin : g_type
      fc_credit_pool #(.HDR_W(HDR_W), .DATA_W(DATA_W)) u_pool (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load[v][t]),
        .update_i   (upd[v][t]),
        .fc_hdr_i   (fc_hdr_i),
        .fc_data_i  (fc_data_i),
        .consume_i  (consume[v][t]),
        .req_data_i (req_data),
        .pass_o     (pass[v][t])
      );
    end
  end

endmodule
